// File: rtl/dh_ctrl_pkg.sv
// dh_ctrl_pkg: shared types and constants for the Diffie-Hellman exchange controller
// Contents: FSM state enum, err_code values, default widths and engine timeout.
package dh_ctrl_pkg;
  localparam int DEF_WIDTH     = 100;
  localparam int DEF_EXP_WIDTH = 101;
  localparam int DEF_TIMEOUT   = 4096;
  typedef enum logic [3:0] {
    IDLE,
    REQ_PUB,
    WAIT_PUB,
    SEND_PUB,
    WAIT_PEER,
    CHECK_PEER,
    REQ_SHR,
    WAIT_SHR,
    DONE,
    ERROR
  } state_t;
  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd1;
  localparam logic [1:0] ERR_PEER_RANGE  = 2'd2;
  localparam logic [1:0] ERR_SECRET_ZERO = 2'd3;
endpackage

// File: rtl/engine_watchdog.sv
// engine_watchdog: bounds the number of cycles an engine request may stay outstanding
// Ports: clk, rst (sync, active-high); clear restarts the count on an engine request;
//        enable counts while a result is awaited; expired flags the last allowed cycle.
module engine_watchdog
  import dh_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // The count equals the cycles elapsed since the request pulse, so the request
  // cycle itself loads 1; expiry on the cycle before TIMEOUT lets the error become
  // visible exactly TIMEOUT cycles after the request.
  always_comb cnt_d = clear ? CW'(1) : (enable && cnt_q != CW'(TIMEOUT)) ? cnt_q + CW'(1) : cnt_q;
  assign expired = enable && cnt_q >= CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dh_exchange_ctrl.sv
// dh_exchange_ctrl: sequences one Diffie-Hellman key agreement over a modexp engine
// Ports: start/generator/prime/secret begin an exchange; me_* is the engine request
//        port; pub_* offers our public key; peer_* accepts the peer key; key_valid/
//        shared_key carry the result; error/err_code report timeout, bad peer, zero secret.
module dh_exchange_ctrl
  import dh_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     generator,
  input  logic [WIDTH-1:0]     prime,
  input  logic [EXP_WIDTH-1:0] secret,
  output logic                 busy,
  output logic                 me_start,
  output logic [WIDTH-1:0]     me_base,
  output logic [WIDTH-1:0]     me_prime,
  output logic [EXP_WIDTH-1:0] me_exp,
  input  logic                 me_done,
  input  logic [WIDTH-1:0]     me_result,
  output logic                 pub_valid,
  input  logic                 pub_ready,
  output logic [WIDTH-1:0]     pub_key,
  input  logic                 peer_valid,
  output logic                 peer_ready,
  input  logic [WIDTH-1:0]     peer_key,
  output logic                 key_valid,
  output logic [WIDTH-1:0]     shared_key,
  output logic                 error,
  output logic [1:0]           err_code
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] me_base_q, me_base_d, me_prime_q, me_prime_d;
  logic [WIDTH-1:0] pub_key_q, pub_key_d, peer_q, peer_d, shared_key_q, shared_key_d;
  logic [EXP_WIDTH-1:0] me_exp_q, me_exp_d;
  logic [1:0] err_code_q, err_code_d;
  logic busy_q, busy_d, me_start_q, me_start_d, pub_valid_q, pub_valid_d;
  logic peer_ready_q, peer_ready_d, key_valid_q, key_valid_d, error_q, error_d;
  logic expired, peer_ok;
  engine_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (me_start_q),
    .enable  (state_q == WAIT_PUB || state_q == WAIT_SHR),
    .expired (expired)
  );
  // The prime >= 4 term guards the subtraction, making the range empty for tiny primes.
  assign peer_ok = peer_q >= WIDTH'(2) && me_prime_q >= WIDTH'(4) && peer_q <= me_prime_q - WIDTH'(2);
  // The me_* registers double as the latched operands: prime and secret stay put for
  // the whole exchange and the base switches to the peer key before the second request.
  always_comb begin
    state_d = state_q;
    me_base_d = me_base_q;
    me_prime_d = me_prime_q;
    me_exp_d = me_exp_q;
    pub_key_d = pub_key_q;
    peer_d = peer_q;
    shared_key_d = shared_key_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        me_base_d = generator;
        me_prime_d = prime;
        me_exp_d = secret;
        pub_key_d = '0;
        shared_key_d = '0;
        err_code_d = secret == '0 ? ERR_SECRET_ZERO : ERR_NONE;
        state_d = secret == '0 ? ERROR : REQ_PUB;
      end
      REQ_PUB: state_d = WAIT_PUB;
      WAIT_PUB: if (me_done) begin
        pub_key_d = me_result;
        state_d = SEND_PUB;
      end else if (expired) begin
        err_code_d = ERR_TIMEOUT;
        state_d = ERROR;
      end
      SEND_PUB: if (pub_ready) state_d = WAIT_PEER;
      WAIT_PEER: if (peer_valid) begin
        peer_d = peer_key;
        state_d = CHECK_PEER;
      end
      CHECK_PEER: if (peer_ok) begin
        me_base_d = peer_q;
        state_d = REQ_SHR;
      end else begin
        err_code_d = ERR_PEER_RANGE;
        state_d = ERROR;
      end
      REQ_SHR: state_d = WAIT_SHR;
      WAIT_SHR: if (me_done) begin
        shared_key_d = me_result;
        state_d = DONE;
      end else if (expired) begin
        err_code_d = ERR_TIMEOUT;
        state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end
  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d = !(state_d == IDLE || state_d == DONE || state_d == ERROR);
    me_start_d = state_d == REQ_PUB || state_d == REQ_SHR;
    pub_valid_d = state_d == SEND_PUB;
    peer_ready_d = state_d == WAIT_PEER;
    key_valid_d = state_d == DONE;
    error_d = state_d == ERROR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      me_base_q <= '0;
      me_prime_q <= '0;
      me_exp_q <= '0;
      pub_key_q <= '0;
      peer_q <= '0;
      shared_key_q <= '0;
      err_code_q <= ERR_NONE;
      busy_q <= 1'b0;
      me_start_q <= 1'b0;
      pub_valid_q <= 1'b0;
      peer_ready_q <= 1'b0;
      key_valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      me_base_q <= me_base_d;
      me_prime_q <= me_prime_d;
      me_exp_q <= me_exp_d;
      pub_key_q <= pub_key_d;
      peer_q <= peer_d;
      shared_key_q <= shared_key_d;
      err_code_q <= err_code_d;
      busy_q <= busy_d;
      me_start_q <= me_start_d;
      pub_valid_q <= pub_valid_d;
      peer_ready_q <= peer_ready_d;
      key_valid_q <= key_valid_d;
      error_q <= error_d;
    end
  end
  assign busy = busy_q;
  assign me_start = me_start_q;
  assign me_base = me_base_q;
  assign me_prime = me_prime_q;
  assign me_exp = me_exp_q;
  assign pub_valid = pub_valid_q;
  assign pub_key = pub_key_q;
  assign peer_ready = peer_ready_q;
  assign key_valid = key_valid_q;
  assign shared_key = shared_key_q;
  assign error = error_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// tb_dh_exchange_ctrl: directed self-checking bench for dh_exchange_ctrl
module tb_dh_exchange_ctrl;
  localparam int W = 100;
  localparam int EW = 101;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] generator = '0, prime = '0, me_result = '0, peer_key = '0;
  logic [EW-1:0] secret = '0;
  logic me_done = 1'b0, pub_ready = 1'b0, peer_valid = 1'b0;
  logic busy, me_start, pub_valid, peer_ready, key_valid, error;
  logic [W-1:0] me_base, me_prime, pub_key, shared_key;
  logic [EW-1:0] me_exp;
  logic [1:0] err_code;
  int n_chk = 0, n_pass = 0, ms_cnt = 0, eng_lat = 20;
  dh_exchange_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .generator(generator), .prime(prime),
    .secret(secret), .busy(busy), .me_start(me_start), .me_base(me_base),
    .me_prime(me_prime), .me_exp(me_exp), .me_done(me_done), .me_result(me_result),
    .pub_valid(pub_valid), .pub_ready(pub_ready), .pub_key(pub_key),
    .peer_valid(peer_valid), .peer_ready(peer_ready), .peer_key(peer_key),
    .key_valid(key_valid), .shared_key(shared_key), .error(error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (me_start) ms_cnt++;
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    logic [2*W-1:0] r, x;
    r = 1;
    x = {{W{1'b0}}, b} % {{W{1'b0}}, m};
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * x) % {{W{1'b0}}, m};
      x = (x * x) % {{W{1'b0}}, m};
    end
    return r[W-1:0];
  endfunction
  // Engine model: answers each request after eng_lat cycles; eng_lat == 0 never answers.
  initial begin
    logic [W-1:0] b, m;
    logic [EW-1:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (me_start && eng_lat != 0) begin
        b = me_base; m = me_prime; e = me_exp; lat = eng_lat;
        repeat (lat - 1) @(negedge clk);
        me_done = 1'b1;
        me_result = modexp(b, e, m);
        @(negedge clk);
        me_done = 1'b0;
      end
    end
  end
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask
  task automatic check_idle(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_me_start"}, me_start, 0);
    check({pfx, "_pub_valid"}, pub_valid, 0);
    check({pfx, "_peer_ready"}, peer_ready, 0);
    check({pfx, "_key_valid"}, key_valid, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_err_code"}, err_code, 0);
    check({pfx, "_pub_key"}, pub_key, 0);
    check({pfx, "_shared_key"}, shared_key, 0);
    check({pfx, "_me_ops"}, {me_base, me_prime, me_exp} == '0, 1);
  endtask
  task automatic do_start(input logic [W-1:0] g, input logic [W-1:0] p, input logic [EW-1:0] a);
    start = 1'b1; generator = g; prime = p; secret = a;
    @(negedge clk);
    start = 1'b0; generator = '0; prime = '0; secret = '0;
  endtask
  task automatic wait_pub(input string tag);
    int n = 0;
    while (!pub_valid && n < 200) begin @(negedge clk); n++; end
    check({tag, "_pub_wait"}, pub_valid, 1);
  endtask
  task automatic wait_key(input string tag);
    int n = 0;
    while (!key_valid && !error && n < 200) begin @(negedge clk); n++; end
    check({tag, "_key_wait"}, key_valid, 1);
  endtask
  task automatic send_pub();
    pub_ready = 1'b1;
    @(negedge clk);
    pub_ready = 1'b0;
  endtask
  task automatic deliver_peer(input logic [W-1:0] k);
    peer_valid = 1'b1; peer_key = k;
    @(negedge clk);
    peer_valid = 1'b0; peer_key = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL sim_watchdog: observed no finish, expected finish");
    $fatal(1);
  end
  initial begin
    logic bad;
    int n, ms0;
    logic [W-1:0] peers [3];
    logic [W-1:0] primes [3];
    peers = '{100'd1, 100'd22, 100'd2};
    primes = '{100'd23, 100'd23, 100'd3};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    // Nominal exchange with 50 cycles of public-key backpressure.
    do_start(5, 23, 6);
    check("nom_me_start", me_start, 1);
    check("nom_me_base", me_base, 5);
    check("nom_me_exp", me_exp, 6);
    check("nom_busy", busy, 1);
    @(negedge clk);
    check("nom_me_start_pulse", me_start, 0);
    wait_pub("nom");
    check("nom_pub_key", pub_key, 8);
    bad = 1'b0;
    repeat (50) begin
      bad |= !pub_valid || pub_key != 8 || peer_ready;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    send_pub();
    check("nom_pub_drop", pub_valid, 0);
    check("nom_peer_ready", peer_ready, 1);
    deliver_peer(19);
    check("nom_check_peer_ready", peer_ready, 0);
    @(negedge clk);
    check("nom_shr_me_start", me_start, 1);
    check("nom_shr_me_base", me_base, 19);
    wait_key("nom");
    check("nom_shared_key", shared_key, 2);
    check("nom_error", error, 0);
    check("nom_busy_done", busy, 0);
    // Peer keys outside [2, p-2], including the empty range of a tiny prime.
    for (int i = 0; i < 3; i++) begin
      ms0 = ms_cnt;
      do_start(2, primes[i], 1);
      wait_pub("range");
      send_pub();
      deliver_peer(peers[i]);
      @(negedge clk);
      check("range_error", error, 1);
      check("range_err_code", err_code, 2);
      repeat (3) @(negedge clk);
      check("range_one_me_start", ms_cnt - ms0, 1);
    end
    // Upper boundary p-2 is accepted.
    do_start(5, 23, 6);
    check("p21_err_cleared", {error, err_code}, 0);
    wait_pub("p21");
    send_pub();
    deliver_peer(21);
    wait_key("p21");
    check("p21_shared_key", shared_key, 18);
    // Timeout: engine never answers.
    eng_lat = 0;
    do_start(5, 23, 6);
    n = 0;
    while (!error && n < 200) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO);
    check("timeout_err_code", err_code, 1);
    check("timeout_busy", busy, 0);
    // Done arriving on the expiry cycle wins.
    eng_lat = TO;
    do_start(5, 23, 6);
    wait_pub("race");
    check("race_no_error", error, 0);
    check("race_pub_key", pub_key, 8);
    // Start while busy is ignored.
    start = 1'b1; generator = 7; prime = 11; secret = 0;
    @(negedge clk);
    start = 1'b0; generator = '0; prime = '0;
    check("busy_start_state", {pub_valid, error}, 2'b10);
    check("busy_start_ops", {me_base, me_prime, me_exp} == {100'd5, 100'd23, 101'd6}, 1);
    eng_lat = 20;
    send_pub();
    deliver_peer(19);
    wait_key("busy_start");
    check("busy_start_shared", shared_key, 2);
    // Zero secret.
    ms0 = ms_cnt;
    do_start(5, 23, 0);
    check("zero_error", error, 1);
    check("zero_err_code", err_code, 3);
    check("zero_key_cleared", {key_valid, shared_key}, 0);
    repeat (3) @(negedge clk);
    check("zero_no_me_start", ms_cnt - ms0, 0);
    // Reset during WAIT_SHR, then the engine's late answer.
    do_start(5, 23, 6);
    wait_pub("rst");
    eng_lat = 30;
    send_pub();
    deliver_peer(19);
    @(negedge clk);
    check("rst_shr_me_start", me_start, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid");
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      bad |= busy || pub_valid || key_valid || error || me_start || shared_key != 0 || pub_key != 0;
    end
    check("late_done_quiet", bad, 0);
    eng_lat = 20;
    do_start(5, 23, 6);
    wait_pub("fresh");
    check("fresh_pub_key", pub_key, 8);
    send_pub();
    deliver_peer(19);
    wait_key("fresh");
    check("fresh_shared_key", shared_key, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dh_exchange_ctrl.md
# dh_exchange_ctrl

Sequencing initiator for one Diffie-Hellman key agreement. On `start` it latches generator, prime and secret exponent, then drives the modular-exponentiation engine through its request port to compute the public key g^a mod p. It offers the public key on a valid/ready output, accepts the peer's public key on a valid/ready input and range-checks it, then drives the engine again for the shared key B^a mod p. It sits between the link/protocol layer and the exponentiation datapath.

## Interface
- `WIDTH`, 100, modulus/base/result width
- `EXP_WIDTH`, 101, exponent width
- `TIMEOUT`, 4096, max cycles from `me_start` to `me_done` before error
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin exchange; accepted only in IDLE, DONE or ERROR
- `generator`, `prime`  in  WIDTH  latched on accepted `start`
- `secret`  in  EXP_WIDTH  latched on accepted `start`
- `busy`  out  1  high in every state except IDLE, DONE and ERROR
- `me_start`  out  1  one-cycle engine request pulse
- `me_base`, `me_prime`  out  WIDTH; `me_exp`  out  EXP_WIDTH  engine operands, held stable from `me_start` until `me_done`
- `me_done`  in  1  one-cycle pulse; `me_result` valid in the same cycle
- `me_result`  in  WIDTH  engine result
- `pub_valid`  out  1; `pub_ready`  in  1; `pub_key`  out  WIDTH  public-key output
- `peer_valid`  in  1; `peer_ready`  out  1; `peer_key`  in  WIDTH  peer-key input
- `key_valid`  out  1; `shared_key`  out  WIDTH  result, held until next accepted `start` or `rst`
- `error`  out  1; `err_code`  out  2  1 = timeout, 2 = peer key out of range, 3 = secret zero

## Operation
- States: IDLE, REQ_PUB, WAIT_PUB, SEND_PUB, WAIT_PEER, CHECK_PEER, REQ_SHR, WAIT_SHR, DONE, ERROR.
- IDLE/DONE/ERROR + `start`: latch operands; clear `key_valid`, `error` and `err_code`; go to ERROR with code 3 if `secret`==0, else go to REQ_PUB.
- REQ_PUB: `me_start`=1 with base=generator and exp=secret; go to WAIT_PUB.
- WAIT_PUB + `me_done`: capture `me_result` into `pub_key`; go to SEND_PUB.
- SEND_PUB: `pub_valid`=1; on `pub_ready` go to WAIT_PEER.
- WAIT_PEER: `peer_ready`=1; on `peer_valid`, capture `peer_key`; go to CHECK_PEER.
- CHECK_PEER: if 2 ≤ peer ≤ prime−2, go to REQ_SHR; else go to ERROR with code 2. Compare at full WIDTH, unsigned. For prime < 4 the range is empty, so the check always fails.
- REQ_SHR: `me_start`=1 with base=peer and exp=secret; go to WAIT_SHR.
- WAIT_SHR + `me_done`: capture `me_result` into `shared_key`; set `key_valid`; go to DONE.
- Watchdog counts only in WAIT_PUB and WAIT_SHR and restarts at each `me_start`. When it reaches TIMEOUT without `me_done`, go to ERROR with code 1.
- `me_done` outside the WAIT states is ignored. `me_done` and timeout in the same cycle: done wins.
- `start` while `busy` is ignored. Operand inputs are ignored except on the accepting cycle.
- `rst` at any point, including mid-exchange: state goes to IDLE and every output goes to 0 on the next edge. The engine is not notified; a late `me_done` after reset is ignored.

## Timing
- Reset values: `busy`, `me_start`, `pub_valid`, `peer_ready`, `key_valid`, `error` = 0; `err_code`, `pub_key`, `shared_key`, `me_*` operands = 0.
- `start` sampled at edge t gives `me_start`=1 during cycle t+1, for exactly one cycle.
- `me_done` at edge d gives `pub_valid`=1 from cycle d+1. `pub_key` is stable while `pub_valid` is high.
- Public-key transfer at edge x gives `pub_valid`=0 and `peer_ready`=1 from x+1.
- Peer-key transfer at edge y: CHECK_PEER in y+1, shared `me_start` in y+2.
- Shared `me_done` at edge z gives `key_valid`=1 and `busy`=0 from z+1.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `dh_ctrl_pkg`: state enum, `err_code` constants (ERR_NONE/TIMEOUT/PEER_RANGE/SECRET_ZERO), default WIDTH/EXP_WIDTH/TIMEOUT.
- One sub-module, `engine_watchdog`: clear, enable, TIMEOUT parameter, `expired` output; $clog2(TIMEOUT+1)-bit counter.
- Range check, operand muxing and the FSM stay in the top module.

## Test plan
- Nominal: p=23, g=5, a=6; bench engine model with 20-cycle latency; peer=19 → `pub_key`=8, `key_valid`=1, `shared_key`=2, `error`=0.
- Backpressure: hold `pub_ready`=0 for 50 cycles → `pub_valid` stays 1 and `pub_key` stays 8; `peer_ready` stays 0 until the transfer.
- Peer range: peer=1 and peer=22 with p=23 → ERROR, `err_code`=2, no second `me_start`. Peer=21 → accepted.
- Timeout: TIMEOUT=64; engine never answers → `error`=1, `err_code`=1 exactly 64 cycles after `me_start`. `me_done` in the same cycle as expiry → no error.
- Secret 0 → ERROR code 3 next cycle, no `me_start`. `start` while busy → ignored; operands unchanged.
- Reset mid-WAIT_SHR, then a late `me_done` → all outputs 0 and state IDLE. A fresh nominal run then yields `shared_key`=2.
